// File: rtl/core_mem_responder.sv
// Single-outstanding memory responder: accepts one core load/store, checks
// alignment, runs a word-aligned bus access with a timeout, and returns one
// response pulse carrying extended load data or an error.
module core_mem_responder #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error,
  output logic        bus_valid,
  output logic [31:0] bus_addr,
  output logic        bus_write,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_wdata,
  input  logic        bus_ready,
  input  logic [31:0] bus_rdata,
  input  logic        bus_error
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BUS_WAIT = 2'd1,
    RESPOND  = 2'd2
  } state_t;

  // Value of the wait counter in the last bus cycle before a timeout.
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [1:0]  lo_q, lo_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic        bus_write_q, bus_write_d;
  logic [3:0]  bus_wstrb_q, bus_wstrb_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_error_q, rsp_error_d;

  // Misaligned halves/words and the reserved size code never reach the bus.
  function automatic logic is_illegal(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      2'b00:   is_illegal = 1'b0;
      2'b01:   is_illegal = lo[0];
      2'b10:   is_illegal = |lo;
      default: is_illegal = 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] store_strobe(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      2'b00:   store_strobe = 4'b0001 << lo;
      2'b01:   store_strobe = 4'b0011 << lo;
      default: store_strobe = 4'b1111;
    endcase
  endfunction

  // Narrow stores are replicated across lanes so the strobe alone picks the bytes.
  function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] wd);
    case (size)
      2'b00:   store_data = {4{wd[7:0]}};
      2'b01:   store_data = {2{wd[15:0]}};
      default: store_data = wd;
    endcase
  endfunction

  // Lane select followed by sign or zero extension of the loaded value.
  function automatic logic [31:0] extend_load(input logic [31:0] word, input logic [1:0] lo,
                                              input logic [1:0] size, input logic uns);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    case (lo)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lo[1] ? word[31:16] : word[15:0];
    case (size)
      2'b00:   extend_load = uns ? {24'd0, b} : 32'(b);
      2'b01:   extend_load = uns ? {16'd0, h} : 32'(h);
      default: extend_load = word;
    endcase
  endfunction

  // Next-state, request capture, bus drive and response formation.
  always_comb begin
    state_d     = state_q;
    lo_d        = lo_q;
    size_d      = size_q;
    uns_d       = uns_q;
    cnt_d       = cnt_q;
    bus_addr_d  = bus_addr_q;
    bus_write_d = bus_write_q;
    bus_wstrb_d = bus_wstrb_q;
    bus_wdata_d = bus_wdata_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_error_d = rsp_error_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          lo_d   = req_addr[1:0];
          size_d = req_size;
          uns_d  = req_unsigned;
          cnt_d  = 16'd0;
          if (is_illegal(req_size, req_addr[1:0])) begin
            state_d     = RESPOND;
            rsp_error_d = 1'b1;
            rsp_rdata_d = 32'd0;
          end else begin
            state_d     = BUS_WAIT;
            bus_addr_d  = {req_addr[31:2], 2'b00};
            bus_write_d = req_write;
            bus_wstrb_d = req_write ? store_strobe(req_size, req_addr[1:0]) : 4'b0000;
            bus_wdata_d = store_data(req_size, req_wdata);
            rsp_error_d = 1'b0;
            rsp_rdata_d = 32'd0;
          end
        end
      end
      BUS_WAIT: begin
        if (bus_ready) begin
          state_d     = RESPOND;
          rsp_error_d = bus_error;
          rsp_rdata_d = (bus_error || bus_write_q) ? 32'd0
                                                   : extend_load(bus_rdata, lo_q, size_q, uns_q);
        end else if (cnt_q == TO_LAST) begin
          state_d     = RESPOND;
          rsp_error_d = 1'b1;
          rsp_rdata_d = 32'd0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      RESPOND: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any transaction in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      lo_q        <= 2'd0;
      size_q      <= 2'd0;
      uns_q       <= 1'b0;
      cnt_q       <= 16'd0;
      bus_addr_q  <= 32'd0;
      bus_write_q <= 1'b0;
      bus_wstrb_q <= 4'd0;
      bus_wdata_q <= 32'd0;
      rsp_rdata_q <= 32'd0;
      rsp_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lo_q        <= lo_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      cnt_q       <= cnt_d;
      bus_addr_q  <= bus_addr_d;
      bus_write_q <= bus_write_d;
      bus_wstrb_q <= bus_wstrb_d;
      bus_wdata_q <= bus_wdata_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_error_q <= rsp_error_d;
    end
  end

  assign req_ready = (state_q == IDLE) && !rst;
  assign bus_valid = (state_q == BUS_WAIT);
  assign rsp_valid = (state_q == RESPOND);
  assign bus_addr  = bus_addr_q;
  assign bus_write = bus_write_q;
  assign bus_wstrb = bus_wstrb_q;
  assign bus_wdata = bus_wdata_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_error = rsp_error_q;

endmodule

// File: tb/tb_core_mem_responder.sv
// Randomized scoreboard bench for core_mem_responder with a behavioural bus slave.
module tb_core_mem_responder;
  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = 32'd0;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_wdata = 32'd0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic        bus_valid;
  logic [31:0] bus_addr;
  logic        bus_write;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_wdata;
  logic        bus_ready = 1'b0;
  logic [31:0] bus_rdata = 32'd0;
  logic        bus_error = 1'b0;

  core_mem_responder #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
    .bus_valid(bus_valid), .bus_addr(bus_addr), .bus_write(bus_write),
    .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata), .bus_ready(bus_ready),
    .bus_rdata(bus_rdata), .bus_error(bus_error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } rsp_t;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic        write;
    int          cyc;
    int          wt;
    logic [31:0] rdata;
    logic        err;
  } bus_t;

  rsp_t rsp_q[$];
  bus_t bus_q[$];

  // Reference load result: shift the addressed lane down, mask, then extend.
  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] sz,
                                             input logic uns, input logic [31:0] rd);
    int unsigned v;
    int unsigned sh;
    sh = a % 4;
    if (sz == 2'b00) begin
      v = (rd >> (8 * sh)) & 32'hFF;
      if (!uns && v >= 128) v = v + 32'hFFFFFF00;
    end else if (sz == 2'b01) begin
      v = (rd >> (8 * (sh / 2) * 2)) & 32'hFFFF;
      if (!uns && v >= 32768) v = v + 32'hFFFF0000;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  // Response monitor: every rsp_valid pulse must match the next expected response.
  rsp_t e_rsp;
  always @(negedge clk) begin
    if (rsp_valid) begin
      if (rsp_q.size() == 0) begin
        checks++;
        $display("FAIL rsp_unexpected: got response rdata 0x%08h err %0b, expected none",
                 rsp_rdata, rsp_error);
      end else begin
        e_rsp = rsp_q.pop_front();
        check("rsp_cycle", 32'(cyc), 32'(e_rsp.cyc));
        check("rsp_error", {31'd0, rsp_error}, {31'd0, e_rsp.err});
        check("rsp_rdata", rsp_rdata, e_rsp.rdata);
      end
    end
  end

  // Bus slave and bus-side monitor: answers after cur.wt wait cycles.
  bus_t cur;
  bit   active = 1'b0;
  int   k = 0;
  always @(negedge clk) begin
    if (bus_valid) begin
      if (!active) begin
        active = 1'b1;
        k = 0;
        if (bus_q.size() == 0) begin
          checks++;
          $display("FAIL bus_unexpected: bus_valid high at addr 0x%08h, expected no bus access",
                   bus_addr);
          cur = '{default: 0};
          cur.wt = 1000;
        end else begin
          cur = bus_q.pop_front();
          check("bus_start_cycle", 32'(cyc), 32'(cur.cyc));
        end
      end
      check("bus_addr", bus_addr, cur.addr);
      check("bus_write", {31'd0, bus_write}, {31'd0, cur.write});
      check("bus_wstrb", {28'd0, bus_wstrb}, {28'd0, cur.wstrb});
      if (cur.write) check("bus_wdata", bus_wdata, cur.wdata);
      check("bus_valid_len",
            {31'd0, (cyc <= cur.cyc + ((cur.wt < T) ? cur.wt : T - 1))}, 32'd1);
      bus_ready = (k == cur.wt);
      bus_error = cur.err && (k == cur.wt);
      bus_rdata = (k == cur.wt) ? cur.rdata : $urandom;
      k++;
    end else begin
      active    = 1'b0;
      bus_ready = 1'b0;
      bus_error = 1'b0;
      bus_rdata = $urandom;
    end
  end

  // Drive one request at a negedge, wait for acceptance, push expectations.
  task automatic issue(input logic [31:0] a, input logic [1:0] sz, input logic wr,
                       input logic uns, input logic [31:0] wd, input int wt,
                       input logic [31:0] rd, input logic er, input bit expect_rsp);
    int   n;
    bit   ill;
    rsp_t r;
    bus_t b;
    req_valid    = 1'b1;
    req_addr     = a;
    req_size     = sz;
    req_write    = wr;
    req_unsigned = uns;
    req_wdata    = wd;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      checks++;
      $display("FAIL req_ready_wait: got req_ready 0 for 50 cycles, expected 1");
      req_valid = 1'b0;
      return;
    end
    ill = (sz == 2'b11) || (sz == 2'b01 && (a % 2) != 0) || (sz == 2'b10 && (a % 4) != 0);
    if (!ill) begin
      b.addr  = a - (a % 4);
      b.write = wr;
      if (!wr)             b.wstrb = 4'd0;
      else if (sz == 2'b00) b.wstrb = 4'(1 << (a % 4));
      else if (sz == 2'b01) b.wstrb = 4'(3 << (a % 4));
      else                 b.wstrb = 4'd15;
      if (sz == 2'b00)      b.wdata = (wd & 32'hFF) * 32'h01010101;
      else if (sz == 2'b01) b.wdata = (wd & 32'hFFFF) * 32'h00010001;
      else                  b.wdata = wd;
      b.cyc   = cyc + 1;
      b.wt    = wt;
      b.rdata = rd;
      b.err   = er;
      bus_q.push_back(b);
    end
    if (expect_rsp) begin
      if (ill)        r.cyc = cyc + 1;
      else if (wt < T) r.cyc = cyc + wt + 2;
      else            r.cyc = cyc + T + 1;
      if (ill || wt >= T) begin
        r.err   = 1'b1;
        r.rdata = 32'd0;
      end else begin
        r.err   = er;
        r.rdata = (er || wr) ? 32'd0 : model_load(a, sz, uns, rd);
      end
      rsp_q.push_back(r);
    end
    @(posedge clk);
    @(negedge clk);
    req_valid    = 1'b0;
    req_addr     = $urandom;
    req_size     = 2'($urandom);
    req_write    = 1'($urandom);
    req_unsigned = 1'($urandom);
    req_wdata    = $urandom;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int n;
    logic [31:0] a;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_req_ready", {31'd0, req_ready}, 32'd0);
    check("reset_bus_valid", {31'd0, bus_valid}, 32'd0);
    check("reset_bus_write", {31'd0, bus_write}, 32'd0);
    check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("reset_rsp_error", {31'd0, rsp_error}, 32'd0);
    check("reset_bus_addr", bus_addr, 32'd0);
    check("reset_bus_wstrb", {28'd0, bus_wstrb}, 32'd0);
    check("reset_bus_wdata", bus_wdata, 32'd0);
    check("reset_rsp_rdata", rsp_rdata, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_reset_req_ready", {31'd0, req_ready}, 32'd1);

    issue(32'h100, 2'b10, 1'b0, 1'b0, 32'd0, 2, 32'hDEADBEEF, 1'b0, 1'b1);
    issue(32'h103, 2'b00, 1'b0, 1'b0, 32'd0, 1, 32'h80FFFFFF, 1'b0, 1'b1);
    issue(32'h103, 2'b00, 1'b0, 1'b1, 32'd0, 0, 32'h80FFFFFF, 1'b0, 1'b1);
    issue(32'h202, 2'b01, 1'b1, 1'b0, 32'h1234ABCD, 1, 32'h55555555, 1'b0, 1'b1);
    issue(32'h101, 2'b10, 1'b0, 1'b0, 32'd0, 0, 32'd0, 1'b0, 1'b1);
    issue(32'h100, 2'b11, 1'b0, 1'b0, 32'd0, 0, 32'd0, 1'b0, 1'b1);
    issue(32'h104, 2'b10, 1'b0, 1'b0, 32'd0, 99, 32'h11111111, 1'b0, 1'b1);
    issue(32'h104, 2'b10, 1'b0, 1'b0, 32'd0, T - 1, 32'hCAFEF00D, 1'b0, 1'b1);
    issue(32'h108, 2'b10, 1'b0, 1'b0, 32'd0, 1, 32'hFFFFFFFF, 1'b1, 1'b1);
    issue(32'h10E, 2'b01, 1'b0, 1'b0, 32'd0, 0, 32'h8001_7FFF, 1'b0, 1'b1);

    // Reset while the bus access is outstanding: no response may follow.
    issue(32'h300, 2'b10, 1'b0, 1'b0, 32'd0, 99, 32'h12345678, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check("rst_bus_valid", {31'd0, bus_valid}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_req_ready", {31'd0, req_ready}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_release_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_release_bus_valid", {31'd0, bus_valid}, 32'd0);

    for (int i = 0; i < 300; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      a = $urandom;
      issue(a, 2'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), $urandom,
            int'($urandom_range(0, T + 1)), $urandom, ($urandom_range(0, 7) == 0), 1'b1);
    end

    n = 0;
    while ((rsp_q.size() != 0 || bus_q.size() != 0) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("drain_rsp_q", 32'(rsp_q.size()), 32'd0);
    check("drain_bus_q", 32'(bus_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
